// File: rtl/operand_sequencer_if.sv
// Operand/result handshakes plus the engine button bus between the sequencer and its neighbours.
interface operand_sequencer_if #(
    parameter int W = 8
);
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         Go;
    logic [W-1:0] DataIn;
    logic [W-1:0] DataResult;
    logic         ResultValid;

    // Upstream/downstream/engine side: everything around the sequencer
    modport master (
        output op_valid, op_a, op_b, res_ready, DataResult, ResultValid,
        input  op_ready, res_valid, res_data, Go, DataIn
    );

    modport slave (
        input  op_valid, op_a, op_b, res_ready, DataResult, ResultValid,
        output op_ready, res_valid, res_data, Go, DataIn
    );
endinterface

// File: rtl/operand_sequencer.sv
// Front-end for the A*A+B engine: replays each (A, B) pair as two Go button presses,
// then waits for ResultValid (with a stall timeout) and hands the result downstream.
module operand_sequencer #(
    parameter int W           = 8,
    parameter int GO_HIGH_CYC = 1,
    parameter int GO_LOW_CYC  = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    operand_sequencer_if.slave   bus,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [15:0]          job_count
);

    localparam int MAXP = (GO_HIGH_CYC > GO_LOW_CYC) ? GO_HIGH_CYC : GO_LOW_CYC;
    localparam int PW   = (MAXP > 2) ? $clog2(MAXP) : 1;
    localparam int TW   = $clog2(TIMEOUT);

    localparam logic [PW-1:0] HIGH_LOAD = PW'(GO_HIGH_CYC - 1);
    localparam logic [PW-1:0] LOW_LOAD  = PW'(GO_LOW_CYC - 1);
    localparam logic [TW-1:0] TLAST     = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        A_PRESS,
        A_REL,
        B_PRESS,
        B_REL,
        WAIT_RES
    } state_t;

    state_t         state, state_d;
    logic [PW-1:0]  pcnt, pcnt_d;
    logic [TW-1:0]  tcnt, tcnt_d;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   data_q, data_d;
    logic [W-1:0]   res_data_q;
    logic           go_q, go_d;
    logic           res_valid_q, res_valid_d;
    logic           op_ready_q, op_ready_d;
    logic           busy_d;
    logic           take_op;
    logic           take_res;
    logic           hit_timeout;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // One press-width counter is reloaded on every state entry; the timeout counter only runs in WAIT_RES
    always_comb begin
        state_d     = state;
        pcnt_d      = pcnt;
        tcnt_d      = tcnt;
        take_op     = 1'b0;
        take_res    = 1'b0;
        hit_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (bus.op_valid && op_ready_q) begin
                    take_op = 1'b1;
                    state_d = A_PRESS;
                    pcnt_d  = HIGH_LOAD;
                end
            end
            A_PRESS: begin
                if (pcnt == '0) begin
                    state_d = A_REL;
                    pcnt_d  = LOW_LOAD;
                end else begin
                    pcnt_d = pcnt - 1'b1;
                end
            end
            A_REL: begin
                if (pcnt == '0) begin
                    state_d = B_PRESS;
                    pcnt_d  = HIGH_LOAD;
                end else begin
                    pcnt_d = pcnt - 1'b1;
                end
            end
            B_PRESS: begin
                if (pcnt == '0) begin
                    state_d = B_REL;
                    pcnt_d  = LOW_LOAD;
                end else begin
                    pcnt_d = pcnt - 1'b1;
                end
            end
            B_REL: begin
                if (pcnt == '0) begin
                    state_d = WAIT_RES;
                    tcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt - 1'b1;
                end
            end
            WAIT_RES: begin
                if (bus.ResultValid) begin
                    take_res = 1'b1;
                    state_d  = IDLE;
                end else if (tcnt == TLAST) begin
                    hit_timeout = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered
        go_d   = (state_d == A_PRESS) || (state_d == B_PRESS);
        data_d = data_q;
        case (state_d)
            A_PRESS:              data_d = take_op ? bus.op_a : a_q;
            A_REL, B_PRESS, B_REL: data_d = b_q;
            default:              data_d = data_q;
        endcase

        if (take_res) begin
            res_valid_d = 1'b1;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end

        op_ready_d = (state_d == IDLE) && !res_valid_d;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pcnt <= '0;
            tcnt <= '0;
        end else begin
            pcnt <= pcnt_d;
            tcnt <= tcnt_d;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            a_q         <= '0;
            b_q         <= '0;
            res_data_q  <= '0;
            job_count   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (take_op) begin
                a_q <= bus.op_a;
                b_q <= bus.op_b;
            end
            if (take_res) begin
                res_data_q <= bus.DataResult;
                job_count  <= job_count + 16'd1;
            end
            if (hit_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            go_q        <= 1'b0;
            data_q      <= '0;
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            busy        <= 1'b0;
        end else begin
            go_q        <= go_d;
            data_q      <= data_d;
            res_valid_q <= res_valid_d;
            op_ready_q  <= op_ready_d;
            busy        <= busy_d;
        end
    end

    assign bus.Go        = go_q;
    assign bus.DataIn    = data_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.op_ready  = op_ready_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: a behavioural A*A+B engine per DUT, directed jobs, and a
// result scoreboard popped by a monitor whenever a result is handed downstream.
module tb_operand_sequencer;

    localparam int W       = 8;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic disc  = 1'b0;

    always #5 clk = ~clk;

    operand_sequencer_if #(.W(W)) bus0 ();
    operand_sequencer_if #(.W(W)) bus1 ();

    logic        busy0, terr0, busy1, terr1;
    logic [15:0] jobs0, jobs1;

    operand_sequencer #(.W(W), .GO_HIGH_CYC(1), .GO_LOW_CYC(1), .TIMEOUT(TIMEOUT)) dut0 (
        .Clock(clk), .Resetn(rst_n), .bus(bus0),
        .busy(busy0), .timeout_err(terr0), .job_count(jobs0)
    );

    operand_sequencer #(.W(W), .GO_HIGH_CYC(3), .GO_LOW_CYC(2), .TIMEOUT(TIMEOUT)) dut1 (
        .Clock(clk), .Resetn(rst_n), .bus(bus1),
        .busy(busy1), .timeout_err(terr1), .job_count(jobs1)
    );

    // Engine model: RV high when idle, falls on the A press, result two cycles after B is released
    typedef enum logic [2:0] {E_IDLE, E_AHELD, E_WAITB, E_BHELD, E_CALC0, E_CALC1} eng_t;
    eng_t       es  [2];
    logic [7:0] ea  [2];
    logic [7:0] eb  [2];
    logic [7:0] er  [2];
    logic       erv [2];
    logic       go_w  [2];
    logic [7:0] din_w [2];

    assign go_w[0]  = bus0.Go;
    assign go_w[1]  = bus1.Go;
    assign din_w[0] = bus0.DataIn;
    assign din_w[1] = bus1.DataIn;
    assign bus0.DataResult  = er[0];
    assign bus0.ResultValid = disc ? 1'b0 : erv[0];
    assign bus1.DataResult  = er[1];
    assign bus1.ResultValid = erv[1];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                es[i]  <= E_IDLE;
                erv[i] <= 1'b1;
                er[i]  <= 8'd0;
                ea[i]  <= 8'd0;
                eb[i]  <= 8'd0;
            end else begin
                case (es[i])
                    E_IDLE:  if (go_w[i]) begin ea[i] <= din_w[i]; erv[i] <= 1'b0; es[i] <= E_AHELD; end
                    E_AHELD: if (!go_w[i]) es[i] <= E_WAITB;
                    E_WAITB: if (go_w[i]) begin eb[i] <= din_w[i]; es[i] <= E_BHELD; end
                    E_BHELD: if (!go_w[i]) es[i] <= E_CALC0;
                    E_CALC0: es[i] <= E_CALC1;
                    E_CALC1: begin er[i] <= ea[i] * ea[i] + eb[i]; erv[i] <= 1'b1; es[i] <= E_IDLE; end
                    default: es[i] <= E_IDLE;
                endcase
            end
        end
    end

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] jobs;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t ex0, ex1;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   exp_jobs0 = 0;
    int   exp_jobs1 = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus0.res_valid && bus0.res_ready) begin
            if (q0.size() == 0) begin
                check_output("dut0 result with empty scoreboard", q0.size(), 1);
            end else begin
                ex0 = q0.pop_front();
                check_output("dut0 res_data", bus0.res_data, ex0.data);
                check_output("dut0 job_count", jobs0, ex0.jobs);
            end
        end
        if (rst_n && bus1.res_valid && bus1.res_ready) begin
            if (q1.size() == 0) begin
                check_output("dut1 result with empty scoreboard", q1.size(), 1);
            end else begin
                ex1 = q1.pop_front();
                check_output("dut1 res_data", bus1.res_data, ex1.data);
                check_output("dut1 job_count", jobs1, ex1.jobs);
            end
        end
    end

    task automatic wait_ready0();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus0.op_ready && g < 200);
        check_output("dut0 op_ready wait", bus0.op_ready, 1);
    endtask

    // Offers a pair at a negedge, returns #1 after the accepting edge
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                  input bit expect_result, input logic [7:0] expd);
        wait_ready0();
        bus0.op_valid = 1'b1;
        bus0.op_a     = a;
        bus0.op_b     = b;
        @(posedge clk);
        #1;
        bus0.op_valid = 1'b0;
        if (expect_result) begin
            exp_jobs0++;
            q0.push_back({expd, 16'(exp_jobs0)});
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8:1]  go_tr;
        logic [8:1]  rv_tr;
        logic [10:1] go_tr1;
        logic [7:0]  din1, din3, held;
        int          g, n, bad_valid, bad_data, bad_ready, bad_busy, din_bad;

        bus0.op_valid = 1'b0; bus0.op_a = '0; bus0.op_b = '0; bus0.res_ready = 1'b1;
        bus1.op_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.res_ready = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset Go", bus0.Go, 0);
        check_output("reset DataIn", bus0.DataIn, 0);
        check_output("reset res_valid", bus0.res_valid, 0);
        check_output("reset res_data", bus0.res_data, 0);
        check_output("reset timeout_err", terr0, 0);
        check_output("reset job_count", jobs0, 0);
        check_output("reset busy", busy0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("op_ready after reset", bus0.op_ready, 1);

        $display("[TB] job A=3 B=4 with cycle trace");
        apply_stimulus(8'd3, 8'd4, 1'b1, 8'd13);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            go_tr[k] = bus0.Go;
            rv_tr[k] = bus0.res_valid;
            if (k == 1) din1 = bus0.DataIn;
            if (k == 3) din3 = bus0.DataIn;
            if (k == 1) check_output("busy during job", busy0, 1);
        end
        check_output("Go trace cycles 1..8", go_tr, 8'h05);
        check_output("res_valid trace cycles 1..8", rv_tr, 8'h80);
        check_output("DataIn on A press", din1, 3);
        check_output("DataIn on B press", din3, 4);

        $display("[TB] back-to-back jobs");
        apply_stimulus(8'd20, 8'd5, 1'b1, 8'd149);
        apply_stimulus(8'd16, 8'd0, 1'b1, 8'd0);

        $display("[TB] downstream backpressure");
        wait_ready0();
        bus0.res_ready = 1'b0;
        apply_stimulus(8'd5, 8'd6, 1'b1, 8'd31);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus0.res_valid && g < 40);
        check_output("res_valid under backpressure", bus0.res_valid, 1);
        held = bus0.res_data;
        bus0.op_valid = 1'b1;
        bus0.op_a     = 8'd9;
        bus0.op_b     = 8'd9;
        bad_valid = 0; bad_data = 0; bad_ready = 0; bad_busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus0.res_valid !== 1'b1) bad_valid++;
            if (bus0.res_data !== held) bad_data++;
            if (bus0.op_ready !== 1'b0) bad_ready++;
            if (busy0 !== 1'b0 || bus0.Go !== 1'b0) bad_busy++;
        end
        check_output("held res_data value", held, 31);
        check_output("res_valid drops while held", bad_valid, 0);
        check_output("res_data changes while held", bad_data, 0);
        check_output("op_ready high while held", bad_ready, 0);
        check_output("pair accepted while held", bad_busy, 0);
        @(posedge clk);
        #1;
        bus0.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("res_valid after transfer", bus0.res_valid, 0);
        check_output("op_ready after transfer", bus0.op_ready, 1);
        check_output("Go before next accept", bus0.Go, 0);
        @(posedge clk);
        #1;
        bus0.op_valid = 1'b0;
        exp_jobs0++;
        q0.push_back({8'd90, 16'(exp_jobs0)});
        @(negedge clk);
        check_output("Go after deferred accept", bus0.Go, 1);
        check_output("DataIn after deferred accept", bus0.DataIn, 9);

        $display("[TB] engine disconnected");
        wait_ready0();
        disc = 1'b1;
        apply_stimulus(8'd1, 8'd1, 1'b0, 8'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!terr0 && n < 60);
        check_output("cycles to timeout_err", n, 4 + TIMEOUT + 1);
        check_output("res_valid after timeout", bus0.res_valid, 0);
        check_output("op_ready after timeout", bus0.op_ready, 1);
        check_output("job_count after timeout", jobs0, exp_jobs0);
        check_output("busy after timeout", busy0, 0);
        disc = 1'b0;
        apply_stimulus(8'd10, 8'd3, 1'b1, 8'd103);
        wait_ready0();
        check_output("timeout_err sticky", terr0, 1);

        $display("[TB] reset during B press");
        apply_stimulus(8'd9, 8'd9, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        check_output("Go in B press", bus0.Go, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("mid reset Go", bus0.Go, 0);
        check_output("mid reset DataIn", bus0.DataIn, 0);
        check_output("mid reset busy", busy0, 0);
        check_output("mid reset timeout_err", terr0, 0);
        check_output("mid reset job_count", jobs0, 0);
        check_output("mid reset res_valid", bus0.res_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_jobs0 = 0;
        apply_stimulus(8'd2, 8'd1, 1'b1, 8'd5);
        wait_ready0();

        $display("[TB] wide press timing on second instance");
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus1.op_ready && g < 100);
        check_output("dut1 op_ready wait", bus1.op_ready, 1);
        bus1.op_valid = 1'b1;
        bus1.op_a     = 8'd7;
        bus1.op_b     = 8'd1;
        @(posedge clk);
        #1;
        bus1.op_valid = 1'b0;
        exp_jobs1++;
        q1.push_back({8'd50, 16'(exp_jobs1)});
        din_bad = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            go_tr1[k] = bus1.Go;
            if (k <= 3 && bus1.DataIn !== 8'd7) din_bad++;
            if (k >= 6 && k <= 8 && bus1.DataIn !== 8'd1) din_bad++;
        end
        check_output("dut1 Go trace cycles 1..10", go_tr1, 10'b0011100111);
        check_output("dut1 DataIn during presses", din_bad, 0);

        g = 0;
        while ((q0.size() != 0 || q1.size() != 0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        check_output("dut0 results outstanding", q0.size(), 0);
        check_output("dut1 results outstanding", q1.size(), 0);
        @(negedge clk);
        check_output("dut1 final job_count", jobs1, 1);
        check_output("dut0 final job_count", jobs0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
